// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Also provides the execute-stage operation codes used to recognise divide requests.
`ifndef DIV_CONTROL
`define DIV_CONTROL  5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL 5'b11011
`endif

package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; the top module registers the partial remainder between iterations.
module div_radix2_step (
    input  logic [32:0] rem_in,
    input  logic        next_bit,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic        quot_bit
);

    logic [33:0] shifted;
    logic [33:0] diff;

    // rem_in is always below the divisor, so bit 33 of the difference is a clean borrow flag.
    assign shifted  = {rem_in, next_bit};
    assign diff     = shifted - {2'b00, divisor};
    assign quot_bit = ~diff[33];
    assign rem_out  = quot_bit ? diff[32:0] : shifted[32:0];

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU: 32 busy cycles, then a one-cycle ready pulse.
// Result is {remainder, quotient}; operands are latched on accept and signs restored at the end.
module div_radix2
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alucontrol_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);
    localparam logic [4:0] MSB_IDX   = 5'd31;

    div_state_t  state_reg;
    logic [4:0]  count_reg;
    logic        signed_reg;
    logic [31:0] dividend_abs_reg;
    logic [31:0] divisor_abs_reg;
    logic [31:0] dividend_raw_reg;
    logic        dividend_neg_reg;
    logic        divisor_neg_reg;
    logic [32:0] rem_reg;
    logic [31:0] quot_reg;

    logic        is_signed_op;
    logic        is_div_op;
    logic        dividend_neg_next;
    logic        divisor_neg_next;
    logic [32:0] step_rem;
    logic        step_bit;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;
    logic [63:0] result_next;

    assign is_signed_op      = (alucontrol_i == `DIV_CONTROL);
    assign is_div_op         = is_signed_op || (alucontrol_i == `DIVU_CONTROL);
    assign dividend_neg_next = is_signed_op && opdata1_i[31];
    assign divisor_neg_next  = is_signed_op && opdata2_i[31];

    div_radix2_step u_step (
        .rem_in   (rem_reg),
        .next_bit (dividend_abs_reg[MSB_IDX - count_reg]),
        .divisor  (divisor_abs_reg),
        .rem_out  (step_rem),
        .quot_bit (step_bit)
    );

    // Final values are taken straight from the last step so the result lands on the BUSY->DONE edge.
    assign quot_raw   = {quot_reg[30:0], step_bit};
    assign rem_raw    = step_rem[31:0];
    assign quot_fixed = (signed_reg && (dividend_neg_reg ^ divisor_neg_reg)) ? -quot_raw : quot_raw;
    assign rem_fixed  = (signed_reg && dividend_neg_reg) ? -rem_raw : rem_raw;

    always_comb begin
        result_next = {rem_fixed, quot_fixed};
        if (divisor_abs_reg == 32'h0) begin
            result_next = {dividend_raw_reg, 32'hFFFF_FFFF};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= DIV_IDLE;
            count_reg        <= 5'd0;
            signed_reg       <= 1'b0;
            dividend_abs_reg <= 32'h0;
            divisor_abs_reg  <= 32'h0;
            dividend_raw_reg <= 32'h0;
            dividend_neg_reg <= 1'b0;
            divisor_neg_reg  <= 1'b0;
            rem_reg          <= 33'h0;
            quot_reg         <= 32'h0;
            result_o         <= 64'h0;
            ready_o          <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state_reg)
                DIV_IDLE: begin
                    if (start_i && !annul_i && is_div_op) begin
                        signed_reg       <= is_signed_op;
                        dividend_abs_reg <= dividend_neg_next ? -opdata1_i : opdata1_i;
                        divisor_abs_reg  <= divisor_neg_next ? -opdata2_i : opdata2_i;
                        dividend_raw_reg <= opdata1_i;
                        dividend_neg_reg <= dividend_neg_next;
                        divisor_neg_reg  <= divisor_neg_next;
                        rem_reg          <= 33'h0;
                        quot_reg         <= 32'h0;
                        count_reg        <= 5'd0;
                        state_reg        <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (annul_i) begin
                        state_reg <= DIV_IDLE;
                    end else begin
                        rem_reg   <= step_rem;
                        quot_reg  <= quot_raw;
                        count_reg <= count_reg + 5'd1;
                        if (count_reg == LAST_ITER) begin
                            result_o  <= result_next;
                            ready_o   <= 1'b1;
                            state_reg <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    state_reg <= DIV_IDLE;
                end
                default: begin
                    state_reg <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule
